alu32: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu32_comb.sv | 37 +++
 rtl/alu32.sv | 42 ++++
 tb/tb_alu32.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the ALU-control opcodes and the datapath width.
// The control unit imports this package too, so both sides agree on the encoding.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/alu32_comb.sv
// Combinational core of the execute-stage ALU.
// Maps an opcode and two operands to the next result value.
// Raises o_valid only for recognised opcodes, so the wrapper can hold its register on NOPs.
module alu32_comb
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_valid
);

  logic w_slt;

  // SLT compares the operands as two's-complement numbers, not as unsigned ones.
  assign w_slt = ($signed(i_a) < $signed(i_b));

  // Decode the opcode; unknown codes give zero data and clear the valid flag.
  always_comb begin
    o_result = '0;
    o_valid  = 1'b1;
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, w_slt};
      ALU_NOR: o_result = ~(i_a | i_b);
      default: begin
        o_result = '0;
        o_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu32.sv
// 32-bit MIPS execute-stage ALU.
// Registers the operation result on each rising edge and holds it on NOP codes.
// Zero is an equality flag for branches and bypasses the register and the reset entirely.
module alu32
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] DataIn1,
  input  logic [DATA_W-1:0] DataIn2,
  input  logic [3:0]        Operation,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_next;
  logic              w_valid;

  alu32_comb u_comb (
    .i_a      (DataIn1),
    .i_b      (DataIn2),
    .i_op     (Operation),
    .o_result (w_next),
    .o_valid  (w_valid)
  );

  // Result register: reset wins, valid opcodes load, NOP codes keep the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_valid) begin
      r_result <= w_next;
    end
  end

  assign Result = r_result;

  // A - B is zero exactly when the operands are equal, so a comparator is enough.
  assign Zero = (DataIn1 == DataIn2);

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32.
// Directed steps cover the opcode table, NOP hold, SLT signedness, wrap-around, Zero and
// synchronous reset, then a randomized phase is checked against an arithmetic reference model.
module tb_alu32;

  logic        clk;
  logic        rst;
  logic [31:0] DataIn1;
  logic [31:0] DataIn2;
  logic [3:0]  Operation;
  logic [31:0] Result;
  logic        Zero;

  int checks;
  int errors;
  logic [31:0] expResult;

  alu32 dut (
    .clk       (clk),
    .rst       (rst),
    .DataIn1   (DataIn1),
    .DataIn2   (DataIn2),
    .Operation (Operation),
    .Result    (Result),
    .Zero      (Zero)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU built from the arithmetic meaning of each opcode; unknown codes hold.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] prev);
    longint la;
    longint lb;
    longint m;
    int sa;
    int sb;
    la = longint'({32'b0, a});
    lb = longint'({32'b0, b});
    m  = longint'(64'h1_0000_0000);
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return 32'((la + lb) % m);
      4'd6:    return 32'((la - lb + m) % m);
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return prev;
    endcase
  endfunction

  // One comparison of a 32-bit observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One cycle: drive at the falling edge, check Zero and that Result has not moved,
  // then check the registered result just after the rising edge.
  task automatic applyStimulus(input string tag, input logic r, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst       = r;
    Operation = op;
    DataIn1   = a;
    DataIn2   = b;
    #1;
    checkOutput({tag, "_zero"}, {31'b0, Zero}, (a == b) ? 32'd1 : 32'd0);
    checkOutput({tag, "_hold_between_edges"}, Result, expResult);
    @(posedge clk);
    #1;
    expResult = r ? 32'h0 : refAlu(op, a, b, expResult);
    checkOutput(tag, Result, expResult);
  endtask

  // Directed sequence followed by randomized traffic.
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    Operation = 4'd0;
    DataIn1   = 32'h0;
    DataIn2   = 32'h0;
    @(posedge clk);
    #1;
    expResult = 32'h0;
    checkOutput("reset", Result, 32'h0);

    applyStimulus("and", 1'b0, 4'd0,  32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("and_const", Result, 32'h0000_0000);
    applyStimulus("or",  1'b0, 4'd1,  32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("or_const", Result, 32'h0000_0FFF);
    applyStimulus("add", 1'b0, 4'd2,  32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("add_const", Result, 32'h0000_0FFF);
    applyStimulus("sub", 1'b0, 4'd6,  32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("sub_const", Result, 32'hFFFF_F1E1);
    applyStimulus("slt", 1'b0, 4'd7,  32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("slt_const", Result, 32'h0000_0001);
    applyStimulus("nor", 1'b0, 4'd12, 32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("nor_const", Result, 32'hFFFF_F000);

    applyStimulus("nop_add", 1'b0, 4'd2,  32'h0000_00F0, 32'h0000_0F0F);
    applyStimulus("nop3",    1'b0, 4'd3,  32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("nop3_const", Result, 32'h0000_0FFF);
    applyStimulus("nop5",    1'b0, 4'd5,  32'h1111_1111, 32'h2222_2222);
    checkOutput("nop5_const", Result, 32'h0000_0FFF);
    applyStimulus("nop15",   1'b0, 4'd15, 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("nop15_const", Result, 32'h0000_0FFF);

    applyStimulus("slt_neg", 1'b0, 4'd7, 32'h8000_0000, 32'h0000_0001);
    checkOutput("slt_neg_const", Result, 32'h0000_0001);
    applyStimulus("slt_swap", 1'b0, 4'd7, 32'h0000_0001, 32'h8000_0000);
    checkOutput("slt_swap_const", Result, 32'h0000_0000);
    applyStimulus("slt_eq", 1'b0, 4'd7, 32'h8000_0000, 32'h8000_0000);
    checkOutput("slt_eq_const", Result, 32'h0000_0000);

    applyStimulus("add_wrap", 1'b0, 4'd2, 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("add_wrap_const", Result, 32'h0000_0000);
    applyStimulus("sub_wrap", 1'b0, 4'd6, 32'h0000_0000, 32'h0000_0001);
    checkOutput("sub_wrap_const", Result, 32'hFFFF_FFFF);

    // Zero must follow operands with no clock edge involved.
    @(negedge clk);
    DataIn1 = 32'h1234_5678;
    DataIn2 = 32'h8765_4321;
    #1;
    checkOutput("zero_ne_async", {31'b0, Zero}, 32'd0);
    DataIn2 = 32'h1234_5678;
    #1;
    checkOutput("zero_eq_async", {31'b0, Zero}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      Operation = 4'(k);
      #0.2;
      checkOutput("zero_every_op", {31'b0, Zero}, 32'd1);
    end
    rst = 1'b1;
    #1;
    checkOutput("zero_in_reset", {31'b0, Zero}, 32'd1);
    rst = 1'b0;
    applyStimulus("zero_reset_cycle", 1'b1, 4'd2, 32'hCAFE_0000, 32'hCAFE_0000);

    // Synchronous reset from a non-zero result: nothing moves until the edge.
    applyStimulus("pre_reset_nor", 1'b0, 4'd12, 32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("pre_reset_const", Result, 32'hFFFF_F000);
    applyStimulus("sync_reset", 1'b1, 4'd12, 32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("sync_reset_const", Result, 32'h0000_0000);
    applyStimulus("post_reset_or", 1'b0, 4'd1, 32'h0000_00F0, 32'h0000_0F0F);
    checkOutput("post_reset_const", Result, 32'h0000_0FFF);

    // Randomized traffic over all sixteen codes with occasional reset and equal operands.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        r;
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'd7;
      r  = ($urandom_range(0, 19) == 0);
      applyStimulus("random", r, op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
